// File: rtl/step_clock_gen_if.sv
// Control and clock-output bundle of the step clock generator.
// Master drives period/run/step; slave returns the processor clocks.
interface step_clock_gen_if #(
    parameter int PRESCALE_W = 16,
    parameter int CNT_W      = 32
);
    logic [PRESCALE_W-1:0] prescale;
    logic                  run;
    logic                  step;
    logic                  clk;
    logic                  clk_e;
    logic                  clk_s;
    logic [1:0]            phase;
    logic                  running;
    logic                  cycle_done;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output prescale, run, step,
        input  clk, clk_e, clk_s, phase,
        input  running, cycle_done, cycle_count
    );

    modport slave (
        input  prescale, run, step,
        output clk, clk_e, clk_s, phase,
        output running, cycle_done, cycle_count
    );
endinterface

// File: rtl/step_clock_gen.sv
// Programmable four-phase processor clock generator with
// run/halt/single-step control and a completed-cycle counter.
module step_clock_gen #(
    parameter int PRESCALE_W = 16,
    parameter int CNT_W      = 32
) (
    input  logic            sys_clk,
    input  logic            reset,
    step_clock_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP
    } state_t;

    localparam logic [PRESCALE_W-1:0] Q_ONE   = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE = 1;

    state_t                state;
    logic [1:0]            phase;
    logic [PRESCALE_W-1:0] qcnt;
    logic [PRESCALE_W-1:0] pre_l;
    logic                  clk_r;
    logic                  clk_e_r;
    logic                  clk_s_r;
    logic                  running_r;
    logic                  done_r;
    logic [CNT_W-1:0]      count;

    // {clk, clk_e, clk_s} for a given phase
    function automatic logic [2:0] decode(input logic [1:0] ph);
        logic [2:0] d;
        d = 3'b000;
        unique case (ph)
            2'd0: d = 3'b110;
            2'd1: d = 3'b111;
            2'd2: d = 3'b010;
            2'd3: d = 3'b000;
        endcase
        return d;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 2'd3;
            qcnt      <= '0;
            pre_l     <= '0;
            clk_r     <= 1'b0;
            clk_e_r   <= 1'b0;
            clk_s_r   <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            count     <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.run || bus.step) begin
                        state     <= bus.run ? RUN : STEP;
                        phase     <= 2'd0;
                        qcnt      <= '0;
                        pre_l     <= bus.prescale;
                        {clk_r, clk_e_r, clk_s_r} <= decode(2'd0);
                        running_r <= 1'b1;
                    end
                end
                default: begin
                    if (qcnt != pre_l) begin
                        qcnt <= qcnt + Q_ONE;
                    end else if (phase != 2'd3) begin
                        qcnt  <= '0;
                        phase <= phase + 2'd1;
                        {clk_r, clk_e_r, clk_s_r} <= decode(phase + 2'd1);
                    end else begin
                        // end of phase 3: the step cycle is complete
                        qcnt   <= '0;
                        count  <= count + CNT_ONE;
                        done_r <= 1'b1;
                        if (bus.run) begin
                            state <= RUN;
                            phase <= 2'd0;
                            pre_l <= bus.prescale;
                            {clk_r, clk_e_r, clk_s_r} <= decode(2'd0);
                        end else begin
                            state     <= IDLE;
                            running_r <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.clk         = clk_r;
    assign bus.clk_e       = clk_e_r;
    assign bus.clk_s       = clk_s_r;
    assign bus.phase       = phase;
    assign bus.running     = running_r;
    assign bus.cycle_done  = done_r;
    assign bus.cycle_count = count;
endmodule
